ic_repl: RTL and testbench

- Parametrised replacement-state engine for the instruction cache; successor to the fixed 4-way LRU field (WAYS*LG_WAYS bits per line).
- Holds per-line, per-way valid bits and age stacks, and returns a victim way for a miss on a line.
- Applies hit, fill and invalidate updates from the cache controller.
- Adds selectable policy (LRU, FIFO, pseudo-random), invalid-first victim choice, and a full-array flush sweep.

---
 rtl/ic_repl.sv | 184 ++++++++++++++++++
 tb/tb_ic_repl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ic_repl.sv
// Replacement-state engine for the instruction cache: per-line valid bits and age stacks,
// victim selection (LRU / FIFO / pseudo-random) and a line-by-line init sweep.
module ic_repl #(
   parameter int          WAYS      = 4,
   parameter int          LINES     = 256,
   parameter int          POLICY    = 0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         LG_WAYS   = $clog2(WAYS),
   localparam int         LG_LINES  = $clog2(LINES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   output logic                ready,
   input  logic                lookup_valid,
   input  logic [LG_LINES-1:0] lookup_line,
   output logic                victim_valid,
   output logic [LG_WAYS-1:0]  victim_way,
   input  logic                upd_valid,
   input  logic [LG_LINES-1:0] upd_line,
   input  logic [LG_WAYS-1:0]  upd_way,
   input  logic [1:0]          upd_op
);

   // state   | meaning
   // ST_INIT | sweeping lines: valid=0, age[w]=w; updates and lookups ignored
   // ST_RUN  | accepting lookups and updates
   typedef enum logic {ST_INIT, ST_RUN} state_t;
   typedef logic [WAYS-1:0][LG_WAYS-1:0] ages_t;

   state_t              state_q, state_d;
   logic [LG_LINES-1:0] cnt_q, cnt_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic                victim_valid_q, victim_valid_d;
   logic [LG_WAYS-1:0]  victim_way_q, victim_way_d;
   logic [WAYS-1:0]     valid_q [LINES];
   logic [WAYS-1:0]     valid_d [LINES];
   ages_t               age_q [LINES];
   ages_t               age_d [LINES];

   logic                upd_en;
   logic [WAYS-1:0]     row_valid, fwd_valid;
   ages_t               row_age, fwd_age;
   logic [LG_WAYS-1:0]  vsel;
   logic                found;

   function automatic ages_t promote(input ages_t a, input logic [LG_WAYS-1:0] way);
      ages_t r;
      r = a;
      for (int w = 0; w < WAYS; w++)
         if (a[w] < a[way]) r[w] = a[w] + 1'b1;
      r[way] = '0;
      return r;
   endfunction

   function automatic ages_t demote(input ages_t a, input logic [LG_WAYS-1:0] way);
      ages_t r;
      r = a;
      for (int w = 0; w < WAYS; w++)
         if (a[w] > a[way]) r[w] = a[w] - 1'b1;
      r[way] = '1;
      return r;
   endfunction

   function automatic ages_t init_ages();
      ages_t r;
      for (int w = 0; w < WAYS; w++) r[w] = LG_WAYS'(w);
      return r;
   endfunction

   assign upd_en = (state_q == ST_RUN) && upd_valid && !flush && !reset;

   always_comb begin
      row_valid = valid_q[upd_line];
      row_age   = age_q[upd_line];
      case (upd_op)
         2'b00: if (POLICY == 0) row_age = promote(row_age, upd_way);
         2'b01: begin
            row_valid[upd_way] = 1'b1;
            row_age            = promote(row_age, upd_way);
         end
         2'b10: begin
            row_valid[upd_way] = 1'b0;
            row_age            = demote(row_age, upd_way);
         end
         default: ;
      endcase

      valid_d = valid_q;
      age_d   = age_q;
      if (state_q == ST_INIT) begin
         valid_d[cnt_q] = '0;
         age_d[cnt_q]   = init_ages();
      end else if (upd_en) begin
         valid_d[upd_line] = row_valid;
         age_d[upd_line]   = row_age;
      end
   end

   // Same-line update is forwarded so the victim reflects post-update state.
   always_comb begin
      if (upd_en && (upd_line == lookup_line)) begin
         fwd_valid = row_valid;
         fwd_age   = row_age;
      end else begin
         fwd_valid = valid_q[lookup_line];
         fwd_age   = age_q[lookup_line];
      end

      vsel  = '0;
      found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !fwd_valid[w]) begin
            vsel  = LG_WAYS'(w);
            found = 1'b1;
         end
      end
      if (!found) begin
         if (POLICY == 2) begin
            vsel = lfsr_q[LG_WAYS-1:0];
         end else begin
            for (int w = 0; w < WAYS; w++)
               if (fwd_age[w] == '1) vsel = LG_WAYS'(w);
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      lfsr_d         = lfsr_q;
      victim_valid_d = 1'b0;
      victim_way_d   = victim_way_q;

      if (state_q == ST_RUN)
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      if (flush) begin
         state_d = ST_INIT;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LG_LINES'(LINES - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (lookup_valid) begin
                  victim_valid_d = 1'b1;
                  victim_way_d   = vsel;
               end
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_INIT;
         cnt_q          <= '0;
         lfsr_q         <= LFSR_SEED;
         victim_valid_q <= 1'b0;
         victim_way_q   <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         lfsr_q         <= lfsr_d;
         victim_valid_q <= victim_valid_d;
         victim_way_q   <= victim_way_d;
      end
   end

   // Storage needs no reset: the init sweep rewrites every line.
   always_ff @(posedge clk) begin
      valid_q <= valid_d;
      age_q   <= age_d;
   end

   assign ready        = (state_q == ST_RUN);
   assign victim_valid = victim_valid_q;
   assign victim_way   = victim_way_q;

endmodule

// File: tb/tb_ic_repl.sv
// Bench for ic_repl: LRU, FIFO and random instances driven in parallel and checked every
// cycle against a recency-list model.
module tb_ic_repl;
   localparam int          WAYS  = 4;
   localparam int          LINES = 256;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic       clk = 1'b0;
   logic       reset, flush, lookup_valid, upd_valid;
   logic [7:0] lookup_line, upd_line;
   logic [1:0] upd_way, upd_op;
   logic [2:0] rdy, vv;
   logic [2:0][1:0] vw;

   int n_vec = 0;
   int n_err = 0;

   // model: ord[p][l][k] = way at recency position k (0 = most recent)
   int          ord [3][LINES][WAYS];
   bit          vld [3][LINES][WAYS];
   bit          rdy_m;
   int          init_left;
   logic [15:0] lfsr_m;
   bit          exp_vv;
   int          exp_vw [3];

   always #5 clk = ~clk;

   ic_repl #(.WAYS(WAYS), .LINES(LINES), .POLICY(0), .LFSR_SEED(SEED)) u_lru (
      .clk(clk), .reset(reset), .flush(flush), .ready(rdy[0]),
      .lookup_valid(lookup_valid), .lookup_line(lookup_line),
      .victim_valid(vv[0]), .victim_way(vw[0]),
      .upd_valid(upd_valid), .upd_line(upd_line), .upd_way(upd_way), .upd_op(upd_op));
   ic_repl #(.WAYS(WAYS), .LINES(LINES), .POLICY(1), .LFSR_SEED(SEED)) u_fifo (
      .clk(clk), .reset(reset), .flush(flush), .ready(rdy[1]),
      .lookup_valid(lookup_valid), .lookup_line(lookup_line),
      .victim_valid(vv[1]), .victim_way(vw[1]),
      .upd_valid(upd_valid), .upd_line(upd_line), .upd_way(upd_way), .upd_op(upd_op));
   ic_repl #(.WAYS(WAYS), .LINES(LINES), .POLICY(2), .LFSR_SEED(SEED)) u_rnd (
      .clk(clk), .reset(reset), .flush(flush), .ready(rdy[2]),
      .lookup_valid(lookup_valid), .lookup_line(lookup_line),
      .victim_valid(vv[2]), .victim_way(vw[2]),
      .upd_valid(upd_valid), .upd_line(upd_line), .upd_way(upd_way), .upd_op(upd_op));

   task automatic chk(string tag, int obs, int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int p = 0; p < 3; p++)
         for (int l = 0; l < LINES; l++)
            for (int w = 0; w < WAYS; w++) begin
               ord[p][l][w] = w;
               vld[p][l][w] = 1'b0;
            end
   endtask

   function automatic int find_pos(int p, int l, int way);
      for (int k = 0; k < WAYS; k++) if (ord[p][l][k] == way) return k;
      return 0;
   endfunction

   task automatic move_front(int p, int l, int way);
      int i;
      i = find_pos(p, l, way);
      for (int k = i; k > 0; k--) ord[p][l][k] = ord[p][l][k-1];
      ord[p][l][0] = way;
   endtask

   task automatic move_back(int p, int l, int way);
      int i;
      i = find_pos(p, l, way);
      for (int k = i; k < WAYS-1; k++) ord[p][l][k] = ord[p][l][k+1];
      ord[p][l][WAYS-1] = way;
   endtask

   function automatic int m_victim(int p, int l);
      for (int w = 0; w < WAYS; w++) if (!vld[p][l][w]) return w;
      if (p == 2) return int'(lfsr_m[1:0]);
      return ord[p][l][WAYS-1];
   endfunction

   function automatic logic [15:0] lfsr_next(logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Advance the model by one clock using the currently driven inputs, then check.
   task automatic cycle();
      bit upd_ok, lk;
      int ul, uw;
      upd_ok = !reset && !flush && rdy_m && upd_valid;
      lk     = !reset && !flush && rdy_m && lookup_valid;
      ul     = int'(upd_line);
      uw     = int'(upd_way);
      for (int p = 0; p < 3; p++) begin
         if (upd_ok) begin
            case (upd_op)
               2'b00: if (p == 0) move_front(p, ul, uw);
               2'b01: begin vld[p][ul][uw] = 1'b1; move_front(p, ul, uw); end
               2'b10: begin vld[p][ul][uw] = 1'b0; move_back(p, ul, uw); end
               default: ;
            endcase
         end
         if (lk) exp_vw[p] = m_victim(p, int'(lookup_line));
         if (reset) exp_vw[p] = 0;
      end
      exp_vv = lk;
      if (reset) begin
         rdy_m = 1'b0; init_left = LINES; lfsr_m = SEED; clear_model();
      end else if (flush) begin
         if (rdy_m) lfsr_m = lfsr_next(lfsr_m);
         rdy_m = 1'b0; init_left = LINES; clear_model();
      end else if (rdy_m) begin
         lfsr_m = lfsr_next(lfsr_m);
      end else begin
         init_left--;
         if (init_left == 0) rdy_m = 1'b1;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 3; p++) begin
         chk($sformatf("ready[p%0d]", p), int'(rdy[p]), int'(rdy_m));
         chk($sformatf("victim_valid[p%0d]", p), int'(vv[p]), int'(exp_vv));
         chk($sformatf("victim_way[p%0d]", p), int'(vw[p]), exp_vw[p]);
      end
   endtask

   task automatic drv(bit lv, int ll, bit uv, int ul, int uw, int uo);
      lookup_valid = lv;
      lookup_line  = 8'(ll);
      upd_valid    = uv;
      upd_line     = 8'(ul);
      upd_way      = 2'(uw);
      upd_op       = 2'(uo);
      cycle();
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < LINES + 20 && !rdy_m; i++) idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      idle();
      reset = 1'b0;
   endtask

   task automatic fill_line(int l);
      for (int w = 0; w < WAYS; w++) drv(0, 0, 1, l, w, 1);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      lookup_valid = 0; lookup_line = 0; upd_valid = 0; upd_line = 0; upd_way = 0; upd_op = 0;
      rdy_m = 0; init_left = LINES; lfsr_m = SEED; exp_vv = 0;
      for (int p = 0; p < 3; p++) exp_vw[p] = 0;
      clear_model();
      @(negedge clk);
      do_reset();
      wait_ready();
      drv(1, 5, 0, 0, 0, 0);

      // recency / insertion order on line 7
      fill_line(7);
      drv(1, 7, 0, 0, 0, 0);
      drv(0, 0, 1, 7, 0, 0);
      drv(1, 7, 0, 0, 0, 0);
      drv(0, 0, 1, 7, 1, 0);
      drv(0, 0, 1, 7, 2, 0);
      drv(1, 7, 0, 0, 0, 0);
      drv(0, 0, 1, 7, 2, 2);
      drv(1, 7, 0, 0, 0, 0);
      drv(0, 0, 1, 7, 2, 1);
      drv(1, 7, 0, 0, 0, 0);
      drv(0, 0, 1, 7, 1, 3);
      drv(1, 7, 0, 0, 0, 0);

      // forwarding on line 9
      fill_line(9);
      drv(1, 9, 0, 0, 0, 0);
      drv(1, 9, 1, 9, 0, 0);
      drv(1, 9, 1, 10, 1, 1);
      drv(1, 9, 1, 9, 3, 2);

      // random sequence on a full line, then restart from the seed
      fill_line(3);
      for (int i = 0; i < 8; i++) drv(1, 3, 0, 0, 0, 0);
      do_reset();
      wait_ready();
      fill_line(3);
      for (int i = 0; i < 8; i++) drv(1, 3, 0, 0, 0, 0);

      // randomized traffic on a few lines
      for (int i = 0; i < 800; i++) begin
         flush = ($urandom_range(399) == 0);
         drv($urandom_range(1), $urandom_range(7), $urandom_range(3) != 0,
             $urandom_range(7), $urandom_range(3), $urandom_range(3));
         flush = 1'b0;
      end
      wait_ready();

      // flush with a colliding update; traffic during the sweep must be ignored
      fill_line(20);
      flush = 1'b1;
      drv(1, 20, 1, 20, 0, 1);
      flush = 1'b0;
      for (int i = 0; i < LINES + 20 && !rdy_m; i++)
         drv($urandom_range(1), $urandom_range(255), 1, $urandom_range(255),
             $urandom_range(3), $urandom_range(2));
      for (int l = 0; l < LINES; l++) drv(1, l, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
